// File: rtl/addsub_pkg.sv
// addsub_pkg: mode encoding and default sizing shared by the pipelined adder/subtractor
package addsub_pkg;
  typedef enum logic {ADD = 1'b0, SUB = 1'b1} mode_e;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_STAGES = 4;
endpackage

// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if: operand/result handshake bundle for pipelined_addsub
interface pipelined_addsub_if import addsub_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
  logic in_valid, in_ready, Cin, Sub, out_valid, out_ready, Cout, Ovf, Zero;
  logic [WIDTH-1:0] A, B, S;
  modport master(output in_valid, A, B, Cin, Sub, out_ready,
                 input in_ready, out_valid, S, Cout, Ovf, Zero);
  modport slave(input in_valid, A, B, Cin, Sub, out_ready,
                output in_ready, out_valid, S, Cout, Ovf, Zero);
endinterface

// File: rtl/carry_slice.sv
// carry_slice: N-bit ripple-carry adder chunk used by each pipeline stage
module carry_slice #(parameter int N = 4) (
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);
  logic [N:0] c;
  always_comb begin
    c = '0;
    Sum = '0;
    c[0] = Cin;
    for (int i = 0; i < N; i++) begin
      Sum[i] = X[i] ^ Y[i] ^ c[i];
      c[i+1] = (X[i] & Y[i]) | (c[i] & (X[i] ^ Y[i]));
    end
    Cout = c[N];
  end
endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked ripple-carry add/sub, one CHUNK per stage, valid/ready flow control
module pipelined_addsub import addsub_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input logic clk,
  input logic rst,
  pipelined_addsub_if.slave io
);
  localparam int CHUNK = WIDTH / STAGES;
  localparam int L = STAGES - 1;
  logic adv, ovf_q, zero_q;
  logic [STAGES-1:0] vld, c_q, c_in, co;
  logic [WIDTH-1:0] a_q [STAGES], b_q [STAGES], s_q [STAGES];
  logic [WIDTH-1:0] a_in [STAGES], b_in [STAGES], s_in [STAGES], s_nx [STAGES];
  logic [CHUNK-1:0] sc [STAGES];
  assign adv = !vld[L] || io.out_ready;
  assign io.in_ready = adv;
  assign io.out_valid = vld[L];
  assign io.S = s_q[L];
  assign io.Cout = c_q[L];
  assign io.Ovf = ovf_q;
  assign io.Zero = zero_q;
  // stage k sees the operands, partial sum and carry left by stage k-1; stage 0 sees the inputs
  always_comb begin
    c_in = (c_q << 1) | STAGES'(io.Cin);
    a_in[0] = io.A;
    b_in[0] = (mode_e'(io.Sub) == SUB) ? ~io.B : io.B;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nx[k] = s_in[k];
      s_nx[k][k*CHUNK +: CHUNK] = sc[k];
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g
    carry_slice #(.N(CHUNK)) u_slice (
      .X(a_in[k][k*CHUNK +: CHUNK]),
      .Y(b_in[k][k*CHUNK +: CHUNK]),
      .Cin(c_in[k]),
      .Sum(sc[k]),
      .Cout(co[k])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) s_q[k] <= '0;
    end else if (adv) begin
      vld <= (vld << 1) | STAGES'(io.in_valid);
      c_q <= co;
      ovf_q <= (a_in[L][WIDTH-1] == b_in[L][WIDTH-1]) && (s_nx[L][WIDTH-1] != a_in[L][WIDTH-1]);
      zero_q <= s_nx[L] == '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_in[k];
        b_q[k] <= b_in[k];
        s_q[k] <= s_nx[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: random and directed stimulus against an arithmetic reference with an in-order scoreboard
module tb_pipelined_addsub;
  localparam int W = 16;
  localparam int ST = 4;
  typedef logic [W+2:0] res_t;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pipelined_addsub_if #(.WIDTH(W)) io();
  pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (.clk(clk), .rst(rst), .io(io));
  res_t q[$];
  int vectors = 0;
  int miscompares = 0;
  int popped = 0;

  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin, logic sub);
    logic [W-1:0] be;
    logic [31:0] full;
    int sv;
    logic [W-1:0] s;
    be = sub ? ~b : b;
    full = 32'(a) + 32'(be) + 32'(cin);
    sv = int'($signed(a)) + int'($signed(be)) + int'(cin);
    s = full[W-1:0];
    return {s, full[W], (sv > 2**(W-1) - 1) || (sv < -(2**(W-1))), s == '0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                     input logic sub, input logic ordy, input logic r, output logic acc);
    @(negedge clk);
    rst = r;
    io.in_valid = v;
    io.A = a;
    io.B = b;
    io.Cin = cin;
    io.Sub = sub;
    io.out_ready = ordy;
    #1;
    acc = 1'b0;
    if (r) q.delete();
    else begin
      chk("in_ready", io.in_ready, !io.out_valid || ordy);
      if (q.size() == 0) chk("spurious out_valid", io.out_valid, 0);
      else if (io.out_valid) begin
        chk("result", {io.S, io.Cout, io.Ovf, io.Zero}, q[0]);
        if (ordy) begin
          void'(q.pop_front());
          popped++;
        end
      end
      if (v && io.in_ready) begin
        q.push_back(model(a, b, cin, sub));
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input logic r);
    logic acc;
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, r, acc);
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] es, input logic ec, input logic eo, input logic ez);
    logic acc;
    cyc(1'b1, a, b, cin, sub, 1'b1, 1'b0, acc);
    chk({name, " accept"}, acc, 1);
    for (int i = 0; i < ST - 1; i++) idle(1'b0);
    chk({name, " early"}, io.out_valid, 0);
    idle(1'b0);
    chk({name, " latency"}, io.out_valid, 1);
    chk({name, " S"}, io.S, es);
    chk({name, " Cout"}, io.Cout, ec);
    chk({name, " Ovf"}, io.Ovf, eo);
    chk({name, " Zero"}, io.Zero, ez);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b0, {(W-1){1'b1}}};
      3: return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    logic acc;
    logic [W-1:0] oa [6];
    logic [W-1:0] ob [6];
    int n, p0, accepted;
    rst = 1'b1;
    io.in_valid = 1'b0;
    io.A = '0;
    io.B = '0;
    io.Cin = 1'b0;
    io.Sub = 1'b0;
    io.out_ready = 1'b0;
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chk("reset out_valid", io.out_valid, 0);
    chk("reset in_ready", io.in_ready, 1);
    chk("reset S", io.S, 0);
    chk("reset flags", {io.Cout, io.Ovf, io.Zero}, 0);
    directed("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    directed("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    directed("sub_pos", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    // six back-to-back ops with the consumer stalled in cycles 5..7
    for (int i = 0; i < 6; i++) begin
      oa[i] = pick();
      ob[i] = pick();
    end
    n = 0;
    p0 = popped;
    for (int c = 1; c <= 16; c++) begin
      cyc(n < 6, n < 6 ? oa[n] : '0, n < 6 ? ob[n] : '0, 1'($urandom), 1'($urandom),
          !(c >= 5 && c <= 7), 1'b0, acc);
      if (c >= 5 && c <= 7) chk("stall in_ready", io.in_ready, 0);
      if (acc) n++;
    end
    chk("stall accepted", n, 6);
    chk("stall delivered", popped - p0, 6);
    // reset with three operations in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, pick(), pick(), 1'b0, 1'b0, 1'b1, 1'b0, acc);
    idle(1'b1);
    idle(1'b0);
    chk("flush out_valid", io.out_valid, 0);
    chk("flush in_ready", io.in_ready, 1);
    for (int i = 0; i < ST + 2; i++) idle(1'b0);
    directed("post_rst", 16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0, 1'b0);
    accepted = 0;
    for (int c = 0; c < 60000 && accepted < 10000; c++) begin
      cyc($urandom_range(0, 3) != 0, pick(), pick(), 1'($urandom), 1'($urandom),
          $urandom_range(0, 9) < 7, 1'b0, acc);
      if (acc) accepted++;
    end
    chk("random ops accepted", accepted, 10000);
    for (int c = 0; c < 50 && q.size() != 0; c++) idle(1'b0);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
